// File: rtl/dsa_step_controller_multi.sv
// Debug step controller: halts the DSA FSMs via fsm_hold and releases bursts of N steps per trigger.
// Latency: hold reasserts the cycle after the stopping event; backpressure: a trigger outside HOLD is dropped.
module dsa_step_controller_multi #(
   parameter  int NUM_FSM = 2,
   parameter  int STATE_W = 4,
   parameter  int NUM_EVT = 2,
   parameter  int CNT_W   = 16,
   localparam int SEL_W   = (NUM_FSM > 1) ? $clog2(NUM_FSM) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_step_enable,
   input  logic                       i_step_trigger,
   input  logic [CNT_W-1:0]           i_step_count,
   input  logic [1:0]                 i_step_granularity,
   input  logic [SEL_W-1:0]           i_fsm_sel,
   input  logic [NUM_FSM*STATE_W-1:0] i_fsm_state,
   input  logic [NUM_EVT-1:0]         i_evt,
   input  logic                       i_bp_enable,
   input  logic [STATE_W-1:0]         i_bp_state,
   input  logic [CNT_W-1:0]           i_timeout_cycles,
   output logic                       o_fsm_hold,
   output logic                       o_step_ack,
   output logic                       o_step_ready,
   output logic                       o_bp_hit,
   output logic                       o_timeout_flag,
   output logic [CNT_W-1:0]           o_steps_remaining,
   output logic [CNT_W-1:0]           o_cycle_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_RUNNING, S_HOLD, S_RELEASE, S_WAIT
   } state_t;

   state_t               r_state;
   logic [STATE_W-1:0]   r_cur_prev;
   logic [SEL_W-1:0]     r_sel_prev;
   logic                 r_trig_prev;
   logic [NUM_EVT-1:0]   r_evt_prev;
   logic                 r_bp_hit;
   logic                 r_timeout_flag;
   logic [CNT_W-1:0]     r_steps;
   logic [CNT_W-1:0]     r_cycle_count;

   logic [STATE_W-1:0]   w_cur;
   logic                 w_state_chg;
   logic                 w_trig_edge;
   logic [NUM_EVT-1:0]   w_evt_edge;
   logic                 w_bp_match;
   logic                 w_stop_evt;
   logic [CNT_W:0]       w_cyc_inc;
   logic                 w_to_hit;
   logic [CNT_W-1:0]     w_cyc_sat;

   always_comb begin
      w_cur = '0;
      for (int i = 0; i < NUM_FSM; i++) begin
         if (i_fsm_sel == SEL_W'(i)) w_cur = i_fsm_state[i*STATE_W +: STATE_W];
      end
   end

   // A select change alters cur without any FSM moving, so it must not count as a step.
   assign w_state_chg = (w_cur != r_cur_prev) && (i_fsm_sel == r_sel_prev);
   assign w_trig_edge = i_step_trigger & ~r_trig_prev;
   assign w_evt_edge  = i_evt & ~r_evt_prev;
   assign w_bp_match  = i_bp_enable && w_state_chg && (w_cur == i_bp_state);

   always_comb begin
      case (i_step_granularity)
         2'd0:    w_stop_evt = w_state_chg;
         2'd1:    w_stop_evt = w_evt_edge[0];
         2'd2:    w_stop_evt = w_evt_edge[NUM_EVT-1];
         default: w_stop_evt = 1'b0;
      endcase
   end

   assign w_cyc_inc = {1'b0, r_cycle_count} + (CNT_W+1)'(1);
   assign w_to_hit  = (i_timeout_cycles != '0) && (w_cyc_inc >= {1'b0, i_timeout_cycles});
   assign w_cyc_sat = (&r_cycle_count) ? r_cycle_count : w_cyc_inc[CNT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_cur_prev     <= '0;
         r_sel_prev     <= '0;
         r_trig_prev    <= 1'b0;
         r_evt_prev     <= '0;
         r_bp_hit       <= 1'b0;
         r_timeout_flag <= 1'b0;
         r_steps        <= '0;
         r_cycle_count  <= '0;
      end else begin
         r_cur_prev  <= w_cur;
         r_sel_prev  <= i_fsm_sel;
         r_trig_prev <= i_step_trigger;
         r_evt_prev  <= i_evt;
         case (r_state)
            S_IDLE: r_state <= i_step_enable ? S_HOLD : S_RUNNING;
            S_RUNNING: begin
               if (w_bp_match) begin
                  r_state  <= S_HOLD;
                  r_bp_hit <= 1'b1;
               end else if (i_step_enable) begin
                  r_state <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (w_trig_edge) begin
                  r_state        <= S_RELEASE;
                  r_bp_hit       <= 1'b0;
                  r_timeout_flag <= 1'b0;
               end else if (!i_step_enable && !r_bp_hit) begin
                  r_state <= S_RUNNING;
               end
            end
            S_RELEASE: begin
               r_steps       <= (i_step_count == '0) ? CNT_W'(1) : i_step_count;
               r_cycle_count <= '0;
               r_state       <= S_WAIT;
            end
            S_WAIT: begin
               r_cycle_count <= w_cyc_sat;
               if (!i_step_enable) begin
                  r_state <= S_RUNNING;
                  r_steps <= '0;
               end else if (w_bp_match) begin
                  r_state  <= S_HOLD;
                  r_bp_hit <= 1'b1;
               end else if (w_stop_evt) begin
                  if (r_steps <= CNT_W'(1)) begin
                     r_steps <= '0;
                     r_state <= S_HOLD;
                  end else begin
                     r_steps <= r_steps - CNT_W'(1);
                  end
               end else if (w_to_hit) begin
                  r_state        <= S_HOLD;
                  r_timeout_flag <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_fsm_hold        = (r_state == S_HOLD);
   assign o_step_ready      = (r_state == S_HOLD);
   assign o_step_ack        = (r_state == S_RELEASE);
   assign o_bp_hit          = r_bp_hit;
   assign o_timeout_flag    = r_timeout_flag;
   assign o_steps_remaining = r_steps;
   assign o_cycle_count     = r_cycle_count;

endmodule

// File: tb/tb_dsa_step_controller_multi.sv
// Bench for dsa_step_controller_multi: directed scenarios then random traffic, all against a burst-level model.
module tb_dsa_step_controller_multi;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_step_enable = 1'b0;
   logic        i_step_trigger = 1'b0;
   logic [15:0] i_step_count = '0;
   logic [1:0]  i_step_granularity = '0;
   logic [0:0]  i_fsm_sel = '0;
   logic [7:0]  i_fsm_state = '0;
   logic [1:0]  i_evt = '0;
   logic        i_bp_enable = 1'b0;
   logic [3:0]  i_bp_state = '0;
   logic [15:0] i_timeout_cycles = '0;
   logic        o_fsm_hold, o_step_ack, o_step_ready, o_bp_hit, o_timeout_flag;
   logic [15:0] o_steps_remaining, o_cycle_count;

   int n_checks = 0;
   int n_errors = 0;

   dsa_step_controller_multi dut (
      .clk(clk), .rst(rst),
      .i_step_enable(i_step_enable), .i_step_trigger(i_step_trigger),
      .i_step_count(i_step_count), .i_step_granularity(i_step_granularity),
      .i_fsm_sel(i_fsm_sel), .i_fsm_state(i_fsm_state), .i_evt(i_evt),
      .i_bp_enable(i_bp_enable), .i_bp_state(i_bp_state),
      .i_timeout_cycles(i_timeout_cycles),
      .o_fsm_hold(o_fsm_hold), .o_step_ack(o_step_ack), .o_step_ready(o_step_ready),
      .o_bp_hit(o_bp_hit), .o_timeout_flag(o_timeout_flag),
      .o_steps_remaining(o_steps_remaining), .o_cycle_count(o_cycle_count)
   );

   always #5 clk = ~clk;

   // Model: phase 0 idle, 1 free running, 2 halted, 3 trigger accepted, 4 burst in flight.
   int m_phase, m_target, m_used, m_waited;
   bit m_bp, m_to;
   int p_cur, p_sel, p_trig, p_evt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_target = 0; m_used = 0; m_waited = 0;
      m_bp = 0; m_to = 0;
      p_cur = 0; p_sel = 0; p_trig = 0; p_evt = 0;
   endtask

   task automatic model_step();
      int cur, sel, evt;
      bit chg, trig, stop, bpm;
      sel  = int'(i_fsm_sel);
      cur  = (int'(i_fsm_state) >> (4 * sel)) & 15;
      evt  = int'(i_evt);
      chg  = (cur != p_cur) && (sel == p_sel);
      trig = i_step_trigger && (p_trig == 0);
      case (int'(i_step_granularity))
         0: stop = chg;
         1: stop = ((evt & 1) != 0) && ((p_evt & 1) == 0);
         2: stop = ((evt & 2) != 0) && ((p_evt & 2) == 0);
         default: stop = 0;
      endcase
      bpm = i_bp_enable && chg && (cur == int'(i_bp_state));
      case (m_phase)
         0: m_phase = i_step_enable ? 2 : 1;
         1: begin
            if (bpm) m_bp = 1;
            if (bpm || i_step_enable) m_phase = 2;
         end
         2: begin
            if (trig) begin m_phase = 3; m_bp = 0; m_to = 0; end
            else if (!i_step_enable && !m_bp) m_phase = 1;
         end
         3: begin
            m_target = (i_step_count == 0) ? 1 : int'(i_step_count);
            m_used = 0; m_waited = 0; m_phase = 4;
         end
         default: begin
            m_waited++;
            if (!i_step_enable) begin m_phase = 1; m_used = m_target; end
            else if (bpm) begin m_bp = 1; m_phase = 2; end
            else if (stop) begin
               m_used++;
               if (m_used >= m_target) m_phase = 2;
            end else if (i_timeout_cycles != 0 && m_waited >= int'(i_timeout_cycles)) begin
               m_to = 1; m_phase = 2;
            end
         end
      endcase
      p_cur = cur; p_sel = sel; p_trig = int'(i_step_trigger); p_evt = evt;
   endtask

   task automatic check_all();
      check("hold",  32'(o_fsm_hold),     32'(m_phase == 2));
      check("ready", 32'(o_step_ready),   32'(m_phase == 2));
      check("ack",   32'(o_step_ack),     32'(m_phase == 3));
      check("bp",    32'(o_bp_hit),       32'(m_bp));
      check("to",    32'(o_timeout_flag), 32'(m_to));
      check("steps", 32'(o_steps_remaining), 32'(m_target - m_used));
      check("cyc",   32'(o_cycle_count),  32'((m_waited > 65535) ? 65535 : m_waited));
   endtask

   // Entered and left at a falling edge; inputs are driven by the caller before the call.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check_all();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("rst_hold",  32'(o_fsm_hold), 32'd0);
      check("rst_ready", 32'(o_step_ready), 32'd0);
      check("rst_ack",   32'(o_step_ack), 32'd0);
      check("rst_bp",    32'(o_bp_hit), 32'd0);
      check("rst_to",    32'(o_timeout_flag), 32'd0);
      check("rst_steps", 32'(o_steps_remaining), 32'd0);
      check("rst_cyc",   32'(o_cycle_count), 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int n;
      model_reset();
      @(negedge clk);
      do_reset();

      // single state-change step
      i_step_enable = 1; i_step_granularity = 0; i_step_count = 0; i_fsm_state = 8'h02;
      cycle(); cycle();
      i_step_trigger = 1; cycle();
      check("t1_ack", 32'(o_step_ack), 32'd1);
      cycle();
      i_fsm_state = 8'h03; cycle();
      check("t1_hold", 32'(o_fsm_hold), 32'd1);

      // three evt[0] steps
      i_step_trigger = 0; i_step_count = 3; i_step_granularity = 1; cycle();
      i_step_trigger = 1; cycle(); cycle();
      for (int i = 0; i < 16; i++) begin
         i_evt = (i == 5 || i == 9 || i == 14) ? 2'b01 : 2'b00;
         cycle();
      end
      check("t2_steps", 32'(o_steps_remaining), 32'd0);
      check("t2_hold", 32'(o_fsm_hold), 32'd1);

      // breakpoint while free running
      i_step_trigger = 0; i_step_enable = 0; i_bp_enable = 1; i_bp_state = 4'h6;
      cycle(); cycle(); cycle();
      check("t3_run", 32'(o_fsm_hold), 32'd0);
      i_fsm_state = 8'h06; cycle();
      cycle(); cycle(); cycle();
      check("t3_bp", 32'(o_bp_hit), 32'd1);
      check("t3_hold", 32'(o_fsm_hold), 32'd1);
      i_step_trigger = 1; cycle(); cycle();
      check("t3_bp_clr", 32'(o_bp_hit), 32'd0);
      i_bp_enable = 0; cycle();

      // watchdog in free-run granularity
      i_step_trigger = 0; i_step_enable = 1; i_step_granularity = 3; i_timeout_cycles = 10;
      cycle(); cycle();
      i_step_trigger = 1; cycle();
      n = 0;
      for (int i = 0; i < 40 && !o_fsm_hold; i++) begin
         cycle();
         if (!o_fsm_hold) n++;
      end
      check("t4_reached", 32'(o_fsm_hold), 32'd1);
      check("t4_wait", 32'(n), 32'd10);
      check("t4_cyc", 32'(o_cycle_count), 32'd10);
      check("t4_to", 32'(o_timeout_flag), 32'd1);

      // select change in WAIT, then leave stepping mode
      i_step_trigger = 0; i_timeout_cycles = 0; i_step_granularity = 0; i_step_count = 4;
      i_fsm_state = 8'h91; cycle(); cycle();
      i_step_trigger = 1; cycle(); cycle();
      i_fsm_sel = 1; cycle();
      check("t5_steps", 32'(o_steps_remaining), 32'd4);
      i_step_enable = 0; cycle();
      check("t5_hold", 32'(o_fsm_hold), 32'd0);
      check("t5_steps0", 32'(o_steps_remaining), 32'd0);

      // asynchronous reset mid-burst
      i_step_trigger = 0; i_step_enable = 1; i_step_granularity = 3; i_step_count = 5;
      cycle(); cycle();
      i_step_trigger = 1; cycle(); cycle(); cycle();
      check("t6_steps", 32'(o_steps_remaining), 32'd5);
      do_reset();
      cycle();

      // random traffic
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 599) == 0) do_reset();
         i_step_enable = ($urandom_range(0, 19) != 0);
         if ($urandom_range(0, 3) == 0) i_step_trigger = ~i_step_trigger;
         i_evt = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
         if ($urandom_range(0, 2) == 0) i_fsm_state = 8'($urandom);
         if ($urandom_range(0, 9) == 0) i_fsm_sel = ~i_fsm_sel;
         if ($urandom_range(0, 29) == 0) begin
            i_step_granularity = 2'($urandom);
            i_step_count = 16'($urandom_range(0, 4));
            i_timeout_cycles = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 30));
            i_bp_enable = ($urandom_range(0, 2) == 0);
            i_bp_state = 4'($urandom);
         end
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
